// File: rtl/io_periph_bank.sv
// Memory-mapped I/O bank: N_HEX seven-segment channels, debounced switches,
// display enable and a free-running cycle counter on a 1-cycle-latency bus.
module io_periph_bank #(
    parameter int N_HEX      = 8,
    parameter int SW_WIDTH   = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic [31:0]           rdata_o,
    output logic                  rvalid_o,
    input  logic [SW_WIDTH-1:0]   io_sw_i,
    output logic [7*N_HEX-1:0]    io_hex_o,
    output logic                  sw_change_o
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [9:0] W_SW    = 10'h040;
    localparam logic [9:0] W_CTRL  = 10'h041;
    localparam logic [9:0] W_CYCLE = 10'h042;

    logic [9:0]          word;
    logic [3:0]          digit_q [N_HEX];
    logic [N_HEX-1:0]    blank_q;
    logic                ctrl_q;
    logic [31:0]         cycle_q;
    logic [31:0]         rd_mux;
    logic [SW_WIDTH-1:0] sync1_q, sync2_q, cand_q, stable_q;
    logic [CW-1:0]       cnt_q;
    logic                unused_bits;

    assign word        = addr_i[11:2];
    assign unused_bits = ^{wdata_i[31:8], wdata_i[6:4], addr_i[1:0]};

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'h0: seg_encode = 7'h40;
            4'h1: seg_encode = 7'h79;
            4'h2: seg_encode = 7'h24;
            4'h3: seg_encode = 7'h30;
            4'h4: seg_encode = 7'h19;
            4'h5: seg_encode = 7'h12;
            4'h6: seg_encode = 7'h02;
            4'h7: seg_encode = 7'h78;
            4'h8: seg_encode = 7'h00;
            4'h9: seg_encode = 7'h10;
            4'hA: seg_encode = 7'h08;
            4'hB: seg_encode = 7'h03;
            4'hC: seg_encode = 7'h46;
            4'hD: seg_encode = 7'h21;
            4'hE: seg_encode = 7'h06;
            default: seg_encode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_HEX; k++) digit_q[k] <= 4'h0;
            blank_q <= '1;
            ctrl_q  <= 1'b1;
            cycle_q <= 32'h0;
        end else begin
            for (int k = 0; k < N_HEX; k++) begin
                if (wr_i && be_i[0] && word == 10'(k)) begin
                    digit_q[k] <= wdata_i[3:0];
                    blank_q[k] <= wdata_i[7];
                end
            end
            if (wr_i && be_i[0] && word == W_CTRL) ctrl_q <= wdata_i[0];
            // A clear write wins over the increment on the same edge.
            if (wr_i && |be_i && word == W_CYCLE) cycle_q <= 32'h0;
            else                                  cycle_q <= cycle_q + 32'h1;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        for (int k = 0; k < N_HEX; k++) begin
            if (word == 10'(k)) rd_mux = {24'h0, blank_q[k], 3'b000, digit_q[k]};
        end
        case (word)
            W_SW:    rd_mux = 32'(stable_q);
            W_CTRL:  rd_mux = {31'h0, ctrl_q};
            W_CYCLE: rd_mux = cycle_q;
            default: ;
        endcase
    end

    // Bus: rd_i sampled at edge t yields rvalid_o=1 with rdata_o for exactly
    // the following cycle; rdata_o is forced to 0 whenever rvalid_o is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
        end else begin
            rvalid_o <= rd_i;
            rdata_o  <= rd_i ? rd_mux : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_hex_o <= '1;
        end else begin
            for (int k = 0; k < N_HEX; k++) begin
                io_hex_o[7*k +: 7] <= (blank_q[k] || !ctrl_q) ? 7'h7F : seg_encode(digit_q[k]);
            end
        end
    end

    // Whole-vector debounce: any bit moving restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            sw_change_o <= 1'b0;
        end else begin
            sync1_q     <= io_sw_i;
            sync2_q     <= sync1_q;
            sw_change_o <= 1'b0;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (cand_q != stable_q) begin
                stable_q    <= cand_q;
                sw_change_o <= 1'b1;
            end
        end
    end
endmodule
